// File: rtl/plot_arbiter_pkg.sv
// plot_arbiter_pkg: shared screen/width defaults and FSM state encodings for plot_arbiter
package plot_arbiter_pkg;
  localparam int X_W_DEF = 9;
  localparam int Y_W_DEF = 8;
  localparam int COLOR_W_DEF = 3;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam logic [2:0] CLEAR_COLOR_DEF = 3'b111;
  typedef enum logic [1:0] {PA_CLEAR = 2'd0, PA_WAIT = 2'd1, PA_RUN = 2'd2} pa_state_e;
endpackage

// File: rtl/plot_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search starts one past ptr_i
// ports: req_i request vector, ptr_i last winner, gnt_o one-hot grant, idx_o grant index
module rr_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);
  logic found;
  int c;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(ptr_i) + k) % NUM_CH;
      if (!found && req_i[c]) begin
        found = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: power-on screen clear, start delay, then round-robin merge of plot channels onto vga_adapter
// ports: CLOCK_50/resetn (sync, active low); ch_plot/ch_x/ch_y/ch_colour in, ch_ready out per channel;
//        src_enable, clearing status; x/y/colour/plot to vga_adapter.
// PLOT_ARB_POWERON_CLEAR_EN: when defined, reset enters the CLEAR state; otherwise it enters WAIT directly.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF,
  parameter int START_DELAY = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic [NUM_CH-1:0]         ch_plot,
  input  logic [NUM_CH*X_W-1:0]     ch_x,
  input  logic [NUM_CH*Y_W-1:0]     ch_y,
  input  logic [NUM_CH*COLOR_W-1:0] ch_colour,
  output logic [NUM_CH-1:0]         ch_ready,
  output logic                      src_enable,
  output logic                      clearing,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOR_W-1:0]        colour,
  output logic                      plot
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);
  localparam logic [DLY_W-1:0] DLY_END = DLY_W'(START_DELAY);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_CH - 1);
`ifdef PLOT_ARB_POWERON_CLEAR_EN
  localparam pa_state_e ST_RST = PA_CLEAR;
`else
  localparam pa_state_e ST_RST = PA_WAIT;
`endif
  pa_state_e state_q, state_d;
  logic [X_W-1:0] cx_q, cx_d, x_q, x_d, sel_x;
  logic [Y_W-1:0] cy_q, cy_d, y_q, y_d, sel_y;
  logic [COLOR_W-1:0] col_q, col_d, sel_c;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic plot_q, plot_d, run, xfer, in_scr, last_x;
  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req_i(ch_plot),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );
  assign run = state_q == PA_RUN;
  assign xfer = run && |gnt;
  assign sel_x = ch_x[gnt_idx*X_W +: X_W];
  assign sel_y = ch_y[gnt_idx*Y_W +: Y_W];
  assign sel_c = ch_colour[gnt_idx*COLOR_W +: COLOR_W];
  assign in_scr = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign last_x = cx_q == X_LAST;
  always_comb begin
    state_d = state_q;
    cx_d = cx_q;
    cy_d = cy_q;
    dly_d = dly_q;
    ptr_d = ptr_q;
    x_d = x_q;
    y_d = y_q;
    col_d = col_q;
    plot_d = 1'b0;
    if (state_q == PA_CLEAR) begin
      x_d = cx_q;
      y_d = cy_q;
      col_d = CLEAR_COLOR;
      plot_d = 1'b1;
      cx_d = last_x ? '0 : cx_q + 1'b1;
      cy_d = last_x ? cy_q + 1'b1 : cy_q;
      state_d = (last_x && cy_q == Y_LAST) ? PA_WAIT : PA_CLEAR;
    end else if (state_q == PA_WAIT) begin
      dly_d = dly_q + 1'b1;
      state_d = (dly_q == DLY_END) ? PA_RUN : PA_WAIT;
    end else if (xfer) begin
      // off-screen pixels are consumed but leave the output registers untouched
      ptr_d = gnt_idx;
      plot_d = in_scr;
      x_d = in_scr ? sel_x : x_q;
      y_d = in_scr ? sel_y : y_q;
      col_d = in_scr ? sel_c : col_q;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_RST;
      cx_q <= '0;
      cy_q <= '0;
      dly_q <= '0;
      ptr_q <= PTR_RST;
      x_q <= '0;
      y_q <= '0;
      col_q <= '0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      dly_q <= dly_d;
      ptr_q <= ptr_d;
      x_q <= x_d;
      y_q <= y_d;
      col_q <= col_d;
      plot_q <= plot_d;
    end
  end
`ifdef PLOT_ARB_POWERON_CLEAR_EN
  // registered alongside each clear pixel so it frames exactly the clear pulses
  logic clearing_q;
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) clearing_q <= 1'b0;
    else clearing_q <= state_q == PA_CLEAR;
  end
  assign clearing = clearing_q;
`else
  assign clearing = 1'b0;
`endif
  assign ch_ready = run ? gnt : '0;
  assign src_enable = run;
  assign x = x_q;
  assign y = y_q;
  assign colour = col_q;
  assign plot = plot_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: scoreboard bench for plot_arbiter (4x3 screen, 3 channels, START_DELAY=2)
module tb_plot_arbiter;
  localparam int N = 3;
`ifdef PLOT_ARB_POWERON_CLEAR_EN
  localparam int CLR = 12;
  localparam int SRC_AT = 15;
  localparam int MID = 5;
`else
  localparam int CLR = 0;
  localparam int SRC_AT = 3;
  localparam int MID = 2;
`endif
  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b0;
  logic [N-1:0] ch_plot = '0;
  logic [N*9-1:0] ch_x = '0;
  logic [N*8-1:0] ch_y = '0;
  logic [N*3-1:0] ch_colour = '0;
  logic [N-1:0] ch_ready;
  logic src_enable, clearing, plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int bx[N], by[N], bc[N];
  int gs[6] = '{1, 2, 0, 1, 2, 0};
  always #5 CLOCK_50 = ~CLOCK_50;
  plot_arbiter #(
    .NUM_CH(N), .X_W(9), .Y_W(8), .COLOR_W(3), .SCREEN_W(4), .SCREEN_H(3),
    .CLEAR_COLOR(3'b111), .START_DELAY(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .ch_plot(ch_plot), .ch_x(ch_x), .ch_y(ch_y),
    .ch_colour(ch_colour), .ch_ready(ch_ready), .src_enable(src_enable), .clearing(clearing),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );
  function automatic logic [31:0] pk(input int xx, input int yy, input int cc, input logic cl);
    return {11'd0, 9'(xx), 8'(yy), 3'(cc), cl};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic cycle();
    @(negedge CLOCK_50);
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) check("stray_plot", 32'(plot), 32'd0);
      else check("pixel", pk(int'(x), int'(y), int'(colour), clearing), exp_q.pop_front());
    end
  endtask
  task automatic set_ch(input int i, input int xx, input int yy, input int cc);
    bx[i] = xx;
    by[i] = yy;
    bc[i] = cc;
    ch_x[i*9 +: 9] = 9'(xx);
    ch_y[i*8 +: 8] = 8'(yy);
    ch_colour[i*3 +: 3] = 3'(cc);
  endtask
  task automatic grant_check(input string tag, input int g);
    logic [N-1:0] want;
    #1;
    want = (g < 0) ? '0 : N'(1 << g);
    check(tag, 32'(ch_ready), 32'(want));
    if (g >= 0 && bx[g] < 4 && by[g] < 3) exp_q.push_back(pk(bx[g], by[g], bc[g], 1'b0));
  endtask
  task automatic push_clear();
    for (int p = 0; p < CLR; p++) exp_q.push_back(pk(p % 4, p / 4, 7, 1'b1));
  endtask
  task automatic startup();
    ch_plot = '1;
    push_clear();
    for (int k = 1; k <= SRC_AT; k++) begin
      cycle();
      check("src_en", 32'(src_enable), 32'(k >= SRC_AT));
      if (k < SRC_AT) check("rdy_idle", 32'(ch_ready), 32'd0);
    end
    ch_plot = '0;
    check("clear_done", 32'(exp_q.size()), 32'd0);
    check("clearing_off", 32'(clearing), 32'd0);
  endtask
  initial begin
    cycle();
    cycle();
    check("rst_out", pk(int'(x), int'(y), int'(colour), clearing), 32'd0);
    check("rst_ctl", 32'({plot, src_enable, ch_ready}), 32'd0);
    resetn = 1'b1;
    push_clear();
    repeat (MID) cycle();
    resetn = 1'b0;
    cycle();
    check("rst_mid_plot", 32'(plot), 32'd0);
    check("rst_mid_src", 32'(src_enable), 32'd0);
    exp_q.delete();
    resetn = 1'b1;
    startup();
    set_ch(0, 2, 1, 4);
    ch_plot = 3'b001;
    grant_check("c0_rdy", 0);
    cycle();
    ch_plot = '0;
    grant_check("c0_idle", -1);
    cycle();
    check("c0_drop", 32'(plot), 32'd0);
    set_ch(0, 0, 0, 1);
    set_ch(1, 1, 2, 2);
    set_ch(2, 3, 1, 6);
    ch_plot = '1;
    foreach (gs[i]) begin
      grant_check("rr", gs[i]);
      cycle();
    end
    ch_plot = '0;
    set_ch(1, 4, 0, 3);
    ch_plot = 3'b010;
    grant_check("clip_x", 1);
    cycle();
    check("clip_x_plot", 32'(plot), 32'd0);
    set_ch(1, 0, 3, 3);
    grant_check("clip_y", 1);
    cycle();
    check("clip_y_plot", 32'(plot), 32'd0);
    set_ch(1, 3, 2, 5);
    grant_check("in_scr", 1);
    cycle();
    ch_plot = '0;
    cycle();
    set_ch(0, 1, 1, 2);
    ch_plot = 3'b001;
    resetn = 1'b0;
    cycle();
    check("rst_run_plot", 32'(plot), 32'd0);
    check("rst_run_src", 32'(src_enable), 32'd0);
    ch_plot = '0;
    resetn = 1'b1;
    check("discard", 32'(exp_q.size()), 32'd0);
    startup();
    cycle();
    check("final_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Parametrised successor to the top-level plot glue between pixel producers and vga_adapter.
- Sequences power-on: clears the screen, waits, then raises src_enable. This generalises the one-cycle has_reset/html_enable start-up.
- Merges NUM_CH independent plot channels (parser, cursor, overlay, ...) onto the single vga_adapter x/y/colour/plot port.
- Uses a round-robin valid/ready handshake and drops out-of-screen coordinates.

Parameters:
- NUM_CH, 2, number of plot source channels (1..8)
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOR_W, 3, colour width
- SCREEN_W, 320, visible width in pixels
- SCREEN_H, 240, visible height in pixels
- CLEAR_COLOR, 3'b111, colour written during clear (white)
- START_DELAY, 1, idle cycles between clear done and src_enable (>=1)

Ports:
- CLOCK_50  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- ch_plot  in  NUM_CH  per-channel pixel valid
- ch_x  in  NUM_CH*X_W  packed x; channel i at bits [i*X_W +: X_W]
- ch_y  in  NUM_CH*Y_W  packed y
- ch_colour  in  NUM_CH*COLOR_W  packed colour
- ch_ready  out  NUM_CH  per-channel accept
- src_enable  out  1  high in RUN; gates producers (parser enable, reset = ~src_enable)
- clearing  out  1  high during CLEAR
- x  out  X_W  to vga_adapter
- y  out  Y_W  to vga_adapter
- colour  out  COLOR_W  to vga_adapter
- plot  out  1  to vga_adapter write strobe

Behaviour:
- Reset (resetn=0 at a posedge) forces the following, regardless of state:
  - state=CLEAR, clear counters cx=cy=0, rr pointer=NUM_CH-1
  - x=y=colour=0, plot=0, src_enable=0, clearing=0, delay counter=0
- Any in-flight pixel is discarded.
- States:
  - CLEAR: clearing=1, ch_ready=0.
    - Each cycle registers x=cx, y=cy, colour=CLEAR_COLOR, plot=1.
    - cx increments. When cx=SCREEN_W-1, cx wraps to 0 and cy increments.
    - After the pixel (SCREEN_W-1, SCREEN_H-1) is issued, go to WAIT.
    - Exactly SCREEN_W*SCREEN_H plot pulses, in row-major order.
  - WAIT: plot=0, ch_ready=0; counts START_DELAY cycles, then goes to RUN.
  - RUN: src_enable=1. Stays in RUN until reset.
- Arbitration in RUN:
  - Combinational grant among channels with ch_plot=1.
  - Search starts at (rr pointer+1) mod NUM_CH.
  - ch_ready[g]=1 only for the granted channel; all other ch_ready bits are 0.
  - A transfer occurs when ch_plot[g] & ch_ready[g]; the rr pointer updates to g on a transfer.
  - The winner's x/y/colour are registered next cycle; plot=1 for exactly one cycle per transfer. Latency is 1 cycle.
  - No request: plot=0; x/y/colour hold their last value.
- Clipping:
  - A transferred pixel with x>=SCREEN_W or y>=SCREEN_H is consumed (ch_ready=1) but does not plot (plot=0).
- Throughput: one pixel per cycle sustained; a channel held continuously valid gets at least 1 of every NUM_CH cycles.
- Producers must hold ch_x/ch_y/ch_colour stable while ch_plot=1 and ch_ready=0.
- Width rules: clear counters are X_W/Y_W bits; comparisons are unsigned. NUM_CH=1 degenerates to a pass-through with 1-cycle latency.

Optional Feature:
- Macro: PLOT_ARB_POWERON_CLEAR_EN.
- Defined: CLEAR state present as described.
- Undefined: reset goes directly to WAIT. clearing is tied to 0. The screen content relies on vga_adapter BACKGROUND_IMAGE. First src_enable occurs START_DELAY+1 cycles after reset release.

Decomposition:
- Shared defines header (the existing X/Y/COLOR width macros) additionally holds:
  - SCREEN_W/SCREEN_H defaults, CLEAR_COLOR default
  - state encodings PA_CLEAR, PA_WAIT, PA_RUN
- One sub-module, rr_arbiter:
  - inputs: NUM_CH request vector, pointer
  - outputs: one-hot grant and grant index
  - purely combinational; pointer register stays in plot_arbiter

Test Plan:
- Configuration: SCREEN_W=4, SCREEN_H=3, START_DELAY=2, clear enabled.
- Reset release -> 12 plot pulses, (0,0),(1,0)..(3,2), colour=3'b111, clearing=1 throughout. Then 2 idle cycles, then src_enable=1 on the 15th cycle after release.
- RUN, ch0 only, valid (2,1,3'b100) -> ch_ready[0]=1 same cycle; next cycle plot=1, x=2, y=1, colour=3'b100. Plot then drops if ch_plot deasserts.
- RUN, NUM_CH=3, all channels continuously valid -> grants 0,1,2,0,1,2. Each output pixel matches its source channel.
- RUN, ch1 sends (4,0) and (0,3) -> both consumed (ch_ready=1), plot stays 0. A following (3,2) plots.
- Assert resetn=0 for one cycle mid-CLEAR (at pixel 5) and mid-RUN with ch0 valid -> next cycle plot=0, src_enable=0. Clear restarts at (0,0); no stale pixel is emitted.
- Macro undefined -> no clear pulses; src_enable=1 three cycles after reset release; clearing stays 0.
